// File: rtl/led_pulse_driver_if.sv
// Button/LED bundle for the pulse driver: raw button levels and burst settings in,
// LED drive and busy flags out.
interface led_pulse_driver_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0] iBtn;
  logic [CNT_W-1:0]  iOnPeriod;
  logic [CNT_W-1:0]  iOffPeriod;
  logic [3:0]        iBlinkCnt;
  logic              iRetrig;
  logic              iEn;
  logic [NUM_CH-1:0] oLED;
  logic [NUM_CH-1:0] oBusy;

  modport master (
    output iBtn, iOnPeriod, iOffPeriod, iBlinkCnt, iRetrig, iEn,
    input  oLED, oBusy
  );

  modport slave (
    input  iBtn, iOnPeriod, iOffPeriod, iBlinkCnt, iRetrig, iEn,
    output oLED, oBusy
  );
endinterface

// File: rtl/led_pulse_driver.sv
// Multi-channel one-shot / blink LED driver: each button rising edge starts a burst of
// B ON periods separated by OFF gaps, with optional retrigger.
module led_pulse_driver #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic               CLK,
  input logic               RESETn,
  led_pulse_driver_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOn   = 2'b01,
    StOff  = 2'b10
  } state_e;

  localparam int unsigned      FillMax  = SYNC_STAGES + 1;
  localparam int unsigned      FillW    = $clog2(FillMax + 1);
  localparam logic [FillW-1:0] FillDone = FillW'(FillMax);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic [FillW-1:0]       r_fill;
  logic                   w_armed;
  logic [SYNC_STAGES-1:0] r_sync [NUM_CH];
  logic [NUM_CH-1:0]      r_prev;
  logic [NUM_CH-1:0]      r_rise;
  state_e                 r_state [NUM_CH];
  logic [CNT_W-1:0]       r_cnt [NUM_CH];
  logic [CNT_W-1:0]       r_on_p [NUM_CH];
  logic [CNT_W-1:0]       r_off_p [NUM_CH];
  logic [3:0]             r_blinks [NUM_CH];
  logic [CNT_W-1:0]       w_on_p;
  logic [CNT_W-1:0]       w_off_p;
  logic [3:0]             w_blinks;
  logic [NUM_CH-1:0]      w_led;
  logic [NUM_CH-1:0]      w_busy;

  // Edges are ignored until the synchroniser and prev flop have refilled after reset,
  // so a button held through reset cannot fire.
  assign w_armed = (r_fill == FillDone);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_fill <= '0;
    end else if (!w_armed) begin
      r_fill <= r_fill + 1'b1;
    end
  end

  // Registered edge stage sets trigger latency to SYNC_STAGES+1 edges.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
      r_rise <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], bus.iBtn[i]};
        r_prev[i] <= r_sync[i][SYNC_STAGES-1];
        r_rise[i] <= r_sync[i][SYNC_STAGES-1] & ~r_prev[i] & w_armed;
      end
    end
  end

  always_comb begin
    w_on_p   = (bus.iOnPeriod == '0) ? CntOne : bus.iOnPeriod;
    w_off_p  = (bus.iOffPeriod == '0) ? CntOne : bus.iOffPeriod;
    w_blinks = (bus.iBlinkCnt == 4'd0) ? 4'd1 : bus.iBlinkCnt;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]  <= StIdle;
        r_cnt[i]    <= '0;
        r_on_p[i]   <= '0;
        r_off_p[i]  <= '0;
        r_blinks[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!bus.iEn) begin
          r_state[i]  <= StIdle;
          r_cnt[i]    <= '0;
          r_blinks[i] <= '0;
        end else if (r_rise[i] && (r_state[i] == StIdle || bus.iRetrig)) begin
          // New burst; a retrigger also wins over the final ON cycle.
          r_state[i]  <= StOn;
          r_on_p[i]   <= w_on_p;
          r_off_p[i]  <= w_off_p;
          r_cnt[i]    <= w_on_p - CntOne;
          r_blinks[i] <= w_blinks - 4'd1;
        end else begin
          case (r_state[i])
            StOn: begin
              if (r_cnt[i] != '0) begin
                r_cnt[i] <= r_cnt[i] - CntOne;
              end else if (r_blinks[i] == 4'd0) begin
                r_state[i] <= StIdle;
              end else begin
                r_state[i]  <= StOff;
                r_cnt[i]    <= r_off_p[i] - CntOne;
                r_blinks[i] <= r_blinks[i] - 4'd1;
              end
            end
            StOff: begin
              if (r_cnt[i] != '0) begin
                r_cnt[i] <= r_cnt[i] - CntOne;
              end else begin
                r_state[i] <= StOn;
                r_cnt[i]   <= r_on_p[i] - CntOne;
              end
            end
            StIdle: begin
              r_state[i] <= StIdle;
            end
            default: begin
              r_state[i] <= StIdle;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    w_led  = '0;
    w_busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_led[i]  = (r_state[i] == StOn);
      w_busy[i] = (r_state[i] != StIdle);
    end
  end

  assign bus.oLED  = w_led;
  assign bus.oBusy = w_busy;

endmodule

// File: doc/led_pulse_driver.md
# led_pulse_driver

Multi-channel, parametrised one-shot and blink LED driver. Each channel synchronises an asynchronous push-button input and detects its rising edge. On that edge the channel drives its LED for a programmable ON period. Optionally it repeats the ON period as a burst of N blinks separated by programmable OFF gaps, with selectable retrigger behaviour. It sits between the board push-buttons and LED pins and replaces the fixed 4-cycle single-channel driver.

## Interface
Parameters:
- NUM_CH, 4, number of independent button/LED channels (1..16)
- CNT_W, 8, width of the ON/OFF period counters
- SYNC_STAGES, 2, button synchroniser depth (>= 2)

Ports:
- CLK  input  1  system clock
- RESETn  input  1  reset, asynchronous, active-low
- iBtn  input  NUM_CH  raw push-button levels, asynchronous to CLK, active-high
- iOnPeriod  input  CNT_W  LED-on duration in CLK cycles; 0 is treated as 1
- iOffPeriod  input  CNT_W  gap between blinks in CLK cycles; 0 is treated as 1
- iBlinkCnt  input  4  blinks per trigger; 0 is treated as 1
- iRetrig  input  1  1 = a new edge restarts an active burst; 0 = edges during a burst are ignored
- iEn  input  1  global enable; 0 forces all channels to IDLE
- oLED  output  NUM_CH  LED drive, active-high
- oBusy  output  NUM_CH  channel is in ON or OFF state

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, then a prev flop. rise = sync_out & ~prev.
- Per-channel FSM with states IDLE, ON, OFF. Per-channel registers: cnt[CNT_W-1:0], blinks_left[3:0], and latched on_p, off_p.
- iOnPeriod, iOffPeriod and iBlinkCnt are latched per channel on each accepted trigger. Changes mid-burst do not affect a running burst.
- IDLE, rise & iEn -> ON:
  - load cnt = max(iOnPeriod,1)-1
  - load blinks_left = max(iBlinkCnt,1)-1
- ON:
  - cnt != 0: decrement.
  - cnt == 0 and blinks_left == 0 -> IDLE.
  - cnt == 0 and blinks_left != 0 -> OFF; cnt = off_p-1; decrement blinks_left.
- OFF:
  - cnt != 0: decrement.
  - cnt == 0 -> ON; cnt = on_p-1.
- Retrigger (rise in ON or OFF):
  - iRetrig=1: reload exactly as from IDLE and go to ON. A restart in ON keeps oLED high with no gap.
  - iRetrig=0: the edge is ignored.
- A rise coinciding with the final cycle of a burst (ON, cnt==0, blinks_left==0):
  - iRetrig=1: retrigger wins; go to ON.
  - iRetrig=0: go to IDLE; the edge is lost.
- iEn=0: all FSMs go to IDLE on the next edge. Counters are cleared. Synchronisers keep running. A button held across iEn rising does not trigger; only a fresh rise does.
- oLED[i] = (state==ON). oBusy[i] = (state!=IDLE). Both are decoded from registered state and are glitch-free.
- Channels are fully independent. Simultaneous triggers on several channels are all serviced.

## Timing
- Reset (RESETn low, asynchronous): synchronisers, prev, cnt and blinks_left go to 0; state goes to IDLE; oLED=0 and oBusy=0 immediately. Deassertion is taken synchronously by the CLK domain.
- Reset mid-burst aborts the burst. No trigger occurs after reset release unless a new rise is seen. A button held through reset counts as prev=1 after the sync fill, so it does not trigger.
- Trigger latency: iBtn stable high before edge k gives oLED high after edge k+SYNC_STAGES+1 (k+3 at the default).
- ON lasts exactly max(on_p,1) cycles. OFF lasts exactly max(off_p,1) cycles.
- Burst length = B*ON + (B-1)*OFF cycles, where B = max(iBlinkCnt,1).
- Minimum re-trigger spacing is 2 cycles of iBtn high/low after synchronisation. Pulses shorter than 1 CLK may be missed; this is acceptable.

## Test plan
- NUM_CH=4, iOnPeriod=4, iBlinkCnt=1: pulse iBtn[0] for 10 cycles -> oLED[0] high exactly 4 cycles starting 3 edges after the rise; other channels stay 0.
- iOnPeriod=3, iOffPeriod=2, iBlinkCnt=3 -> oLED pattern 111 00 111 00 111; oBusy high for 13 cycles.
- iOnPeriod=0, iOffPeriod=0, iBlinkCnt=0 -> single 1-cycle oLED pulse.
- iRetrig=1, ON=8: second rise 5 cycles into ON -> oLED stays high continuously, 5+8 cycles total. Repeat with iRetrig=0 -> 8 cycles only.
- Rises on all 4 channels in the same cycle with different periods latched -> each channel times independently. Changing iOnPeriod mid-burst has no effect on the running burst.
- RESETn low for 1 cycle in the middle of OFF -> oLED and oBusy drop asynchronously. Holding iBtn high through reset gives no trigger; iEn=0 mid-ON -> IDLE on the next edge.
